x_mem_arb: RTL and testbench
============================

X_MEM_ARB -- requirements
Module: x_mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 1024: cycles a granted transfer may wait for i_accept before abort; legal range 2..65535.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_nrst  input  1  reset; synchronous, active-low; sampled on rising edge of i_clk.
REQ-004 i_m0_valid  input  1  requester 0 transfer request, held until o_m0_accept.
REQ-005 i_m0_rnw  input  1  requester 0 read (1) / write (0).
REQ-006 i_m0_addr  input  32  requester 0 address.
REQ-007 i_m0_data  input  32  requester 0 write data.
REQ-008 o_m0_accept  output  1  requester 0 transfer complete, single-cycle pulse.
REQ-009 o_m0_data  output  32  requester 0 read data, valid with o_m0_accept.
REQ-010 o_m0_err  output  1  requester 0 transfer aborted by timeout, coincident with o_m0_accept.
REQ-011 i_m1_valid, i_m1_rnw, i_m1_addr, i_m1_data, o_m1_accept, o_m1_data, o_m1_err: requester 1, same widths and meaning as REQ-004..REQ-010.
REQ-012 o_valid  output  1  memory request.
REQ-013 o_rnw  output  1  memory read/write.
REQ-014 o_addr  output  32  memory address.
REQ-015 o_data  output  32  memory write data.
REQ-016 i_accept  input  1  memory completion, same-cycle with i_data.
REQ-017 i_data  input  32  memory read data.

Function
REQ-018 States: IDLE, BUSY0, BUSY1; a 1-bit priority pointer prio (0 = requester 0 favoured); a 16-bit wait counter cnt.
REQ-019 IDLE: no request forwarded; o_valid=0, o_addr/o_rnw/o_data=0, all accepts/errs=0.
REQ-020 IDLE, only requester n valid -> BUSYn next cycle; both valid -> BUSY[prio] next cycle; none -> stay IDLE.
REQ-021 Grant latency: request sampled in IDLE in cycle t, forwarded to memory in cycle t+1.
REQ-022 BUSYn: o_valid=i_mn_valid, o_rnw/o_addr/o_data = requester n fields combinationally; other requester sees accept=0, err=0, data=0.
REQ-023 BUSYn with i_accept=1: o_mn_accept=1, o_mn_data=i_data, o_mn_err=0 same cycle; next state IDLE; prio <= ~n.
REQ-024 After any completion the arbiter always spends one cycle in IDLE; a requester valid in its accept cycle is never re-granted on that sample.
REQ-025 cnt cleared on IDLE->BUSY transition; increments each BUSY cycle without i_accept; saturates, never wraps.
REQ-026 Timeout: in BUSYn with cnt==TIMEOUT-1 and i_accept=0 -> o_mn_accept=1, o_mn_err=1, o_mn_data=0 same cycle; next state IDLE; prio <= ~n.
REQ-027 i_accept and timeout in same cycle: normal completion wins, o_mn_err=0, data=i_data.
REQ-028 Requester n drops i_mn_valid while BUSYn (protocol violation): o_valid=0 that cycle, next state IDLE, no accept/err, prio unchanged.
REQ-029 i_accept while IDLE ignored; no state or output change.
REQ-030 o_mN_data is 0 whenever o_mN_accept=0.

Reset
REQ-031 i_nrst=0 at a rising edge: state <= IDLE, prio <= 0, cnt <= 0; synchronous, no asynchronous path.
REQ-032 Outputs during and after reset, until next grant: o_valid=0, o_rnw=0, o_addr=0, o_data=0, o_m0/m1_accept=0, o_m0/m1_err=0, o_m0/m1_data=0.
REQ-033 Reset in BUSYn mid-transfer: transfer abandoned, no accept pulse issued to requester n, IDLE next cycle.

Verification
REQ-034 Single read: m0 valid, rnw=1, addr=0x100 at t; o_valid=1, o_addr=0x100 at t+1; i_accept=1, i_data=0xCAFEF00D at t+3 -> o_m0_accept=1, o_m0_data=0xCAFEF00D at t+3, IDLE at t+4.
REQ-035 Contention: m0 and m1 both valid from reset -> m0 served first; after its accept m1 granted at accept+2; third simultaneous round -> m0 again (alternation m0,m1,m0,m1).
REQ-036 Write pass-through: m1 valid, rnw=0, addr=0x2000, data=0x12345678 -> o_rnw=0, o_addr=0x2000, o_data=0x12345678 in BUSY1; o_m1_data=0 on accept.
REQ-037 Timeout: TIMEOUT=4, m0 valid, i_accept held 0 -> o_m0_accept=1, o_m0_err=1, o_m0_data=0 on 4th BUSY0 cycle; repeat with i_accept=1 on that cycle -> err=0.
REQ-038 Reset mid-transfer: i_nrst=0 on 2nd BUSY1 cycle -> no o_m1_accept, o_valid=0 next cycle, prio=0; both requesting afterwards -> m0 granted.
REQ-039 Valid drop: m1 granted, i_m1_valid deasserted before i_accept -> o_valid=0 same cycle, IDLE next, no accept, prio unchanged.

Source files
------------

// File: rtl/x_mem_arb.sv
// Two-requester memory arbiter with alternating priority and a per-transfer
// timeout that completes a stalled transfer with an error flag.
module x_mem_arb #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_m0_valid,
  input  logic        i_m0_rnw,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  output logic        o_m0_accept,
  output logic [31:0] o_m0_data,
  output logic        o_m0_err,
  input  logic        i_m1_valid,
  input  logic        i_m1_rnw,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  output logic        o_m1_accept,
  output logic [31:0] o_m1_data,
  output logic        o_m1_err,
  output logic        o_valid,
  output logic        o_rnw,
  output logic [31:0] o_addr,
  output logic [31:0] o_data,
  input  logic        i_accept,
  input  logic [31:0] i_data
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [15:0] cnt_q, cnt_d;

  logic        sel;
  logic        busy;
  logic        req_valid;
  logic        req_rnw;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        done;
  logic        err;
  logic [31:0] rsp_data;

  // Outputs are forced idle while reset is held so an abandoned transfer
  // can never produce an accept pulse in the reset cycle itself.
  assign sel       = (state_q == BUSY1);
  assign busy      = i_nrst && (state_q == BUSY0 || state_q == BUSY1);
  assign req_valid = sel ? i_m1_valid : i_m0_valid;
  assign req_rnw   = sel ? i_m1_rnw   : i_m0_rnw;
  assign req_addr  = sel ? i_m1_addr  : i_m0_addr;
  assign req_data  = sel ? i_m1_data  : i_m0_data;
  assign done      = busy && req_valid && (i_accept || cnt_q == CntLast);
  assign err       = done && !i_accept;
  assign rsp_data  = err ? 32'd0 : i_data;

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement leaves it unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    o_valid     = 1'b0;
    o_rnw       = 1'b0;
    o_addr      = 32'd0;
    o_data      = 32'd0;
    o_m0_accept = 1'b0;
    o_m0_err    = 1'b0;
    o_m0_data   = 32'd0;
    o_m1_accept = 1'b0;
    o_m1_err    = 1'b0;
    o_m1_data   = 32'd0;

    case (state_q)
      IDLE: begin
        if (i_m0_valid && (!i_m1_valid || !prio_q)) begin
          state_d = BUSY0;
          cnt_d   = 16'd0;
        end else if (i_m1_valid) begin
          state_d = BUSY1;
          cnt_d   = 16'd0;
        end
      end
      BUSY0, BUSY1: begin
        if (!req_valid) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = IDLE;
          prio_d  = ~sel;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (busy) begin
      o_valid = req_valid;
      o_rnw   = req_rnw;
      o_addr  = req_addr;
      o_data  = req_data;
    end

    if (done && !sel) begin
      o_m0_accept = 1'b1;
      o_m0_err    = err;
      o_m0_data   = rsp_data;
    end
    if (done && sel) begin
      o_m1_accept = 1'b1;
      o_m1_err    = err;
      o_m1_data   = rsp_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_x_mem_arb.sv
// Directed bench for x_mem_arb (TIMEOUT=4): inputs change 1 time unit after
// the rising edge, outputs are compared on the falling edge.
module tb_x_mem_arb;

  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_m0_valid, i_m0_rnw, i_m1_valid, i_m1_rnw;
  logic [31:0] i_m0_addr, i_m0_data, i_m1_addr, i_m1_data;
  logic        o_m0_accept, o_m0_err, o_m1_accept, o_m1_err;
  logic [31:0] o_m0_data, o_m1_data;
  logic        o_valid, o_rnw, i_accept;
  logic [31:0] o_addr, o_data, i_data;

  int checks = 0;
  int errors = 0;

  x_mem_arb #(.TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_m0_valid(i_m0_valid), .i_m0_rnw(i_m0_rnw), .i_m0_addr(i_m0_addr),
    .i_m0_data(i_m0_data), .o_m0_accept(o_m0_accept), .o_m0_data(o_m0_data),
    .o_m0_err(o_m0_err),
    .i_m1_valid(i_m1_valid), .i_m1_rnw(i_m1_rnw), .i_m1_addr(i_m1_addr),
    .i_m1_data(i_m1_data), .o_m1_accept(o_m1_accept), .o_m1_data(o_m1_data),
    .o_m1_err(o_m1_err),
    .o_valid(o_valid), .o_rnw(o_rnw), .o_addr(o_addr), .o_data(o_data),
    .i_accept(i_accept), .i_data(i_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
  endtask

  initial begin
    i_nrst = 1'b0;
    i_m0_valid = 1'b1; i_m0_rnw = 1'b1; i_m0_addr = 32'h0; i_m0_data = 32'h0;
    i_m1_valid = 1'b0; i_m1_rnw = 1'b0; i_m1_addr = 32'h0; i_m1_data = 32'h0;
    i_accept = 1'b1; i_data = 32'hFFFF_FFFF;

    // Reset held with stray request and memory accept: everything quiet.
    next_cyc();
    mid();
    check("rst_valid", o_valid, 0);
    check("rst_addr", o_addr, 0);
    check("rst_m0_accept", o_m0_accept, 0);
    check("rst_m0_data", o_m0_data, 0);

    // Single read from m0.
    next_cyc();
    i_nrst = 1'b1; i_accept = 1'b0; i_data = 32'h0;
    i_m0_valid = 1'b1; i_m0_rnw = 1'b1; i_m0_addr = 32'h100;
    mid();
    check("rd_t_valid", o_valid, 0);
    next_cyc();
    mid();
    check("rd_t1_valid", o_valid, 1);
    check("rd_t1_addr", o_addr, 32'h100);
    check("rd_t1_rnw", o_rnw, 1);
    next_cyc();
    mid();
    check("rd_t2_accept", o_m0_accept, 0);
    next_cyc();
    i_accept = 1'b1; i_data = 32'hCAFE_F00D;
    mid();
    check("rd_t3_accept", o_m0_accept, 1);
    check("rd_t3_data", o_m0_data, 32'hCAFE_F00D);
    check("rd_t3_err", o_m0_err, 0);
    check("rd_t3_m1_accept", o_m1_accept, 0);

    // Write pass-through from m1 (prio now favours m1).
    next_cyc();
    i_accept = 1'b0; i_data = 32'h0; i_m0_valid = 1'b0;
    i_m1_valid = 1'b1; i_m1_rnw = 1'b0; i_m1_addr = 32'h2000; i_m1_data = 32'h1234_5678;
    mid();
    check("rd_t4_valid", o_valid, 0);
    check("rd_t4_m0_data", o_m0_data, 0);
    next_cyc();
    i_accept = 1'b1;
    mid();
    check("wr_valid", o_valid, 1);
    check("wr_rnw", o_rnw, 0);
    check("wr_addr", o_addr, 32'h2000);
    check("wr_data", o_data, 32'h1234_5678);
    check("wr_m1_accept", o_m1_accept, 1);
    check("wr_m1_data", o_m1_data, 0);
    check("wr_m0_accept", o_m0_accept, 0);

    // Contention after reset: m0, m1, m0 with one idle cycle between.
    next_cyc();
    i_accept = 1'b0; i_m1_valid = 1'b0; i_nrst = 1'b0;
    next_cyc();
    i_nrst = 1'b1;
    i_m0_valid = 1'b1; i_m0_rnw = 1'b1; i_m0_addr = 32'hA0;
    i_m1_valid = 1'b1; i_m1_rnw = 1'b1; i_m1_addr = 32'hB0;
    mid();
    check("arb_idle0_valid", o_valid, 0);
    next_cyc();
    i_accept = 1'b1; i_data = 32'h1111;
    mid();
    check("arb_r1_addr", o_addr, 32'hA0);
    check("arb_r1_m0_accept", o_m0_accept, 1);
    check("arb_r1_m1_accept", o_m1_accept, 0);
    next_cyc();
    i_accept = 1'b0;
    mid();
    check("arb_idle1_valid", o_valid, 0);
    next_cyc();
    i_accept = 1'b1; i_data = 32'h2222;
    mid();
    check("arb_r2_addr", o_addr, 32'hB0);
    check("arb_r2_m1_accept", o_m1_accept, 1);
    check("arb_r2_m1_data", o_m1_data, 32'h2222);
    check("arb_r2_m0_accept", o_m0_accept, 0);
    next_cyc();
    i_accept = 1'b0;
    mid();
    check("arb_idle2_valid", o_valid, 0);
    next_cyc();
    i_accept = 1'b1; i_data = 32'h3333;
    mid();
    check("arb_r3_addr", o_addr, 32'hA0);
    check("arb_r3_m0_accept", o_m0_accept, 1);

    // Timeout on the 4th BUSY0 cycle, then accept on that same cycle.
    next_cyc();
    i_accept = 1'b0; i_data = 32'h55; i_m1_valid = 1'b0;
    i_m0_valid = 1'b1; i_m0_addr = 32'h300;
    next_cyc();
    mid();
    check("to_c1_accept", o_m0_accept, 0);
    next_cyc();
    next_cyc();
    mid();
    check("to_c3_accept", o_m0_accept, 0);
    next_cyc();
    mid();
    check("to_c4_accept", o_m0_accept, 1);
    check("to_c4_err", o_m0_err, 1);
    check("to_c4_data", o_m0_data, 0);
    next_cyc();
    mid();
    check("to_idle_valid", o_valid, 0);
    check("to_idle_err", o_m0_err, 0);
    next_cyc();
    next_cyc();
    next_cyc();
    next_cyc();
    i_accept = 1'b1; i_data = 32'h77;
    mid();
    check("to2_c4_accept", o_m0_accept, 1);
    check("to2_c4_err", o_m0_err, 0);
    check("to2_c4_data", o_m0_data, 32'h77);

    // Reset on the 2nd BUSY1 cycle; prio returns to m0.
    next_cyc();
    i_accept = 1'b0; i_m0_valid = 1'b0;
    i_m1_valid = 1'b1; i_m1_addr = 32'h400;
    next_cyc();
    mid();
    check("mr_c1_valid", o_valid, 1);
    next_cyc();
    i_nrst = 1'b0;
    mid();
    check("mr_c2_m1_accept", o_m1_accept, 0);
    check("mr_c2_valid", o_valid, 0);
    next_cyc();
    i_nrst = 1'b1; i_m0_valid = 1'b1;
    mid();
    check("mr_after_valid", o_valid, 0);
    check("mr_after_m1_accept", o_m1_accept, 0);
    next_cyc();
    i_accept = 1'b1; i_data = 32'h88;
    mid();
    check("mr_grant_addr", o_addr, 32'h300);
    check("mr_grant_m0_accept", o_m0_accept, 1);

    // m1 drops valid mid-transfer; prio stays on m1; idle accept ignored.
    next_cyc();
    i_accept = 1'b0; i_m0_valid = 1'b0;
    mid();
    check("vd_idle_valid", o_valid, 0);
    next_cyc();
    mid();
    check("vd_c1_valid", o_valid, 1);
    check("vd_c1_addr", o_addr, 32'h400);
    next_cyc();
    i_m1_valid = 1'b0;
    mid();
    check("vd_drop_valid", o_valid, 0);
    check("vd_drop_accept", o_m1_accept, 0);
    check("vd_drop_err", o_m1_err, 0);
    next_cyc();
    i_accept = 1'b1; i_data = 32'h99;
    i_m0_valid = 1'b1; i_m1_valid = 1'b1;
    mid();
    check("idle_acc_valid", o_valid, 0);
    check("idle_acc_m0_accept", o_m0_accept, 0);
    check("idle_acc_m1_accept", o_m1_accept, 0);
    check("idle_acc_m0_data", o_m0_data, 0);
    next_cyc();
    i_accept = 1'b0;
    mid();
    check("vd_prio_addr", o_addr, 32'h400);
    check("vd_prio_m1_accept", o_m1_accept, 0);
    next_cyc();
    i_accept = 1'b1; i_data = 32'hAB;
    mid();
    check("vd_final_accept", o_m1_accept, 1);
    check("vd_final_data", o_m1_data, 32'hAB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
